// File: rtl/mngr_pkg.sv
// mngr_pkg: CSR addresses and response FSM states shared by the manager CSR bridge.
package mngr_pkg;
  localparam logic [11:0] CSR_MNGR2PROC = 12'hFC0;
  localparam logic [11:0] CSR_PROC2MNGR = 12'h7C0;
  localparam logic [11:0] CSR_COREID    = 12'hF14;
  localparam logic [11:0] CSR_NUMCORES  = 12'hFC1;
  localparam logic [11:0] CSR_SENTCNT   = 12'hFC2;
  typedef enum logic {IDLE, RESP} state_e;
endpackage

// File: rtl/vr_queue.sv
// vr_queue: val/rdy FIFO; accepts a new entry while full if the head leaves in the same cycle.
module vr_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [W-1:0] enq_msg,
  output logic         deq_val,
  input  logic         deq_rdy,
  output logic [W-1:0] deq_msg
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_cnt;
  logic w_enq, w_deq;
  assign deq_val = r_cnt != '0;
  assign enq_rdy = r_cnt != FULL || deq_rdy;
  assign w_enq = enq_val && enq_rdy;
  assign w_deq = deq_val && deq_rdy;
  assign deq_msg = r_mem[r_head];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail == LAST ? '0 : r_tail + 1'b1;
      if (w_deq) r_head <= r_head == LAST ? '0 : r_head + 1'b1;
      r_cnt <= r_cnt + CW'(w_enq) - CW'(w_deq);
    end
  end
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= enq_msg;
  end
endmodule

// File: rtl/mngr_csr_bridge.sv
// mngr_csr_bridge: maps pipeline CSR accesses onto manager message channels
// and a few read-only identity/status CSRs, with a one-cycle registered response.
module mngr_csr_bridge
  import mngr_pkg::*;
#(
  parameter int QDEPTH    = 2,
  parameter int CORE_ID   = 0,
  parameter int NUM_CORES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_val,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic        mngr2proc_val,
  output logic        mngr2proc_rdy,
  input  logic [31:0] mngr2proc_msg,
  output logic        proc2mngr_val,
  input  logic        proc2mngr_rdy,
  output logic [31:0] proc2mngr_msg,
  output logic [15:0] sent_cnt
);
  state_e r_state, w_state_next;
  logic w_is_m2p, w_is_p2m, w_legal, w_fire, w_enq_rdy, w_deq_val;
  logic [31:0] w_rdata, r_rdata;
  logic r_err;
  logic [15:0] r_sent_cnt;
  assign w_is_m2p = req_addr == CSR_MNGR2PROC;
  assign w_is_p2m = req_addr == CSR_PROC2MNGR;
  always_comb begin
    w_legal = req_wr ? w_is_p2m
            : (w_is_m2p || req_addr == CSR_COREID || req_addr == CSR_NUMCORES || req_addr == CSR_SENTCNT);
    w_rdata = (req_wr || !w_legal) ? '0
            : w_is_m2p ? mngr2proc_msg
            : req_addr == CSR_COREID ? 32'(CORE_ID)
            : req_addr == CSR_NUMCORES ? 32'(NUM_CORES)
            : {16'h0, r_sent_cnt};
    req_rdy = !rst && ((!req_wr && w_is_m2p) ? mngr2proc_val
            : (req_wr && w_is_p2m) ? w_enq_rdy : 1'b1);
    w_fire = req_val && req_rdy;
    mngr2proc_rdy = w_fire && !req_wr && w_is_m2p;
    w_state_next = w_fire ? RESP : IDLE;
  end
  vr_queue #(.DEPTH(QDEPTH), .W(32)) u_p2m_q (
    .clk     (clk),
    .rst     (rst),
    .enq_val (w_fire && req_wr && w_is_p2m),
    .enq_rdy (w_enq_rdy),
    .enq_msg (req_wdata),
    .deq_val (w_deq_val),
    .deq_rdy (proc2mngr_rdy),
    .deq_msg (proc2mngr_msg)
  );
  assign proc2mngr_val = w_deq_val && !rst;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      if (w_fire) begin
        r_rdata <= w_rdata;
        r_err <= !w_legal;
      end
      if (proc2mngr_val && proc2mngr_rdy) r_sent_cnt <= r_sent_cnt + 16'd1;
    end
  end
  assign resp_val = r_state == RESP;
  assign resp_rdata = r_rdata;
  assign resp_err = r_err;
  assign sent_cnt = r_sent_cnt;
endmodule

// File: tb/tb_mngr_csr_bridge.sv
// tb_mngr_csr_bridge: scoreboard bench; responses and outgoing messages are
// predicted from the driven requests and compared as the bridge produces them.
module tb_mngr_csr_bridge;
  localparam int QD = 2;
  localparam int CID = 3;
  localparam int NC = 4;
  logic clk = 0, rst = 1;
  logic req_val = 0, req_rdy, req_wr = 0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic resp_val, resp_err;
  logic [31:0] resp_rdata;
  logic mngr2proc_val = 0, mngr2proc_rdy;
  logic [31:0] mngr2proc_msg = '0;
  logic proc2mngr_val, proc2mngr_rdy = 1;
  logic [31:0] proc2mngr_msg;
  logic [15:0] sent_cnt;
  int checks = 0, failures = 0;
  logic [32:0] sb_q[$];
  logic [31:0] p2m_q[$];
  logic [15:0] m_sent = '0;
  logic exp_rdy, fire;
  logic [32:0] e;

  mngr_csr_bridge #(.QDEPTH(QD), .CORE_ID(CID), .NUM_CORES(NC)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_val(resp_val), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mngr2proc_val(mngr2proc_val), .mngr2proc_rdy(mngr2proc_rdy), .mngr2proc_msg(mngr2proc_msg),
    .proc2mngr_val(proc2mngr_val), .proc2mngr_rdy(proc2mngr_rdy), .proc2mngr_msg(proc2mngr_msg),
    .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [32:0] model(input logic wr, input logic [11:0] a);
    if (wr) return a == 12'h7C0 ? 33'h0 : {1'b1, 32'h0};
    case (a)
      12'hFC0: return {1'b0, mngr2proc_msg};
      12'hF14: return {1'b0, 32'(CID)};
      12'hFC1: return {1'b0, 32'(NC)};
      12'hFC2: return {1'b0, 16'h0, m_sent};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      p2m_q.delete();
      m_sent = '0;
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_m2p_rdy", mngr2proc_rdy, 0);
    end else begin
      chk("resp_val", resp_val, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (resp_val) begin
          chk("resp_rdata", resp_rdata, e[31:0]);
          chk("resp_err", resp_err, e[32]);
        end
      end
      exp_rdy = (!req_wr && req_addr == 12'hFC0) ? mngr2proc_val
              : (req_wr && req_addr == 12'h7C0) ? (p2m_q.size() < QD || proc2mngr_rdy) : 1'b1;
      fire = req_val && exp_rdy;
      chk("req_rdy", req_rdy, exp_rdy);
      chk("m2p_rdy", mngr2proc_rdy, fire && !req_wr && req_addr == 12'hFC0);
      chk("sent_cnt", sent_cnt, m_sent);
      chk("p2m_val", proc2mngr_val, p2m_q.size() != 0);
      if (fire) sb_q.push_back(model(req_wr, req_addr));
      if (proc2mngr_val && proc2mngr_rdy && p2m_q.size() != 0) begin
        chk("p2m_msg", proc2mngr_msg, p2m_q.pop_front());
        m_sent++;
      end
      if (fire && req_wr && req_addr == 12'h7C0) p2m_q.push_back(req_wdata);
    end
  end

  task automatic csr(input logic wr, input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    req_val = 1; req_wr = wr; req_addr = a; req_wdata = d;
    forever begin
      @(negedge clk);
      if (req_rdy) break;
      if (++n > 100) begin
        chk("req_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1 req_val = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_resp_val", resp_val, 0);
    chk("reset_sent", sent_cnt, 0);
    mngr2proc_msg = 32'h21; mngr2proc_val = 1;
    csr(0, 12'hFC0, 0);
    mngr2proc_val = 0;
    csr(1, 12'h7C0, 32'h4B);
    repeat (2) @(negedge clk);
    chk("sent_after_4b", sent_cnt, 1);
    @(posedge clk); #1;
    csr(0, 12'hF14, 0);
    csr(0, 12'hFC1, 0);
    csr(0, 12'hFC2, 0);
    proc2mngr_rdy = 0;
    csr(1, 12'h7C0, 32'h1);
    csr(1, 12'h7C0, 32'h2);
    fork
      csr(1, 12'h7C0, 32'h3);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("full_blocked", req_rdy, 0);
        end
        @(posedge clk);
        #1 proc2mngr_rdy = 1;
      end
    join
    repeat (4) @(negedge clk);
    chk("sent_after_123", sent_cnt, 4);
    @(posedge clk); #1;
    mngr2proc_val = 0;
    fork
      csr(0, 12'hFC0, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("m2p_wait_rdy", req_rdy, 0);
          chk("m2p_wait_resp", resp_val, 0);
        end
        @(posedge clk);
        #1 mngr2proc_msg = 32'h99; mngr2proc_val = 1;
      end
    join
    mngr2proc_val = 0;
    csr(0, 12'h123, 0);
    csr(1, 12'hF14, 32'h5);
    csr(0, 12'h7C0, 0);
    @(negedge clk);
    chk("err_no_enq", proc2mngr_val, 0);
    @(posedge clk); #1;
    proc2mngr_rdy = 0;
    csr(1, 12'h7C0, 32'hA);
    csr(1, 12'h7C0, 32'hB);
    csr(0, 12'hF14, 0);
    rst = 1; req_val = 1; req_wr = 0; req_addr = 12'hFC0; mngr2proc_val = 1;
    @(posedge clk);
    #1 rst = 0; req_val = 0; mngr2proc_val = 0;
    @(negedge clk);
    chk("post_rst_p2m_val", proc2mngr_val, 0);
    chk("post_rst_resp_val", resp_val, 0);
    chk("post_rst_sent", sent_cnt, 0);
    proc2mngr_rdy = 1;
    csr(1, 12'h7C0, 32'hC);
    csr(0, 12'hFC2, 0);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("p2m_drained", p2m_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
